// File: rtl/hash_pkg.sv
// Shared types and constants for the Hash160 message loader.
package hash_pkg;

    localparam int unsigned LEN_W       = 64;
    localparam int unsigned BLOCK_W_DEF = 512;
    localparam logic [7:0]  START_CODE_DEF = 8'hAA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2
    } state_e;

    // Default block-with-flags entry; the loader re-declares it for its BLOCK_W.
    typedef struct packed {
        logic [BLOCK_W_DEF-1:0] block;
        logic                   first;
        logic                   is_final;
    } hash_blk_t;

endpackage

// File: rtl/hash_blk_fifo.sv
// Shift-style block FIFO (1 or 2 entries); the head entry is always a register.
module hash_blk_fifo
    import hash_pkg::*;
#(
    parameter type         T     = hash_blk_t,
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [IW-1:0] wr_idx;

    // A concurrent pop shifts entries down, so the write slot moves with it.
    always_comb begin
        wr_idx = pop ? IW'(cnt - CW'(1)) : IW'(cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i + 1 < DEPTH; i++) mem[i] <= mem[i+1];
                mem[DEPTH-1] <= '0;
            end
            if (push) mem[wr_idx] <= din;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem[0];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/hash_msg_loader.sv
// Word-serial framed message loader packing MSB-first blocks for the Hash160 core.
// Define LOADER_PAD_EN to append SHA-style padding (1-bit, zeros, 64-bit length) in hardware.
module hash_msg_loader
    import hash_pkg::*;
#(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned BLOCK_W    = 512,
    parameter logic [7:0]  START_CODE = START_CODE_DEF,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_W-1:0]    i_text,
    input  logic               i_valid,
    input  logic               i_last,
    output logic               o_ready,
    output logic [BLOCK_W-1:0] o_block,
    output logic               o_block_valid,
    input  logic               i_block_ready,
    output logic               o_first,
    output logic               o_final,
    output logic               o_err
);

    localparam int unsigned WORDS = BLOCK_W / IN_W;
    localparam int unsigned KW    = $clog2(WORDS);
    localparam int unsigned BW    = $clog2(BLOCK_W);
    localparam logic [1:0]  S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0]  S_LOAD = 2'(ST_LOAD);

    typedef struct packed {
        logic [BLOCK_W-1:0] block;
        logic               first;
        logic               is_final;
    } blk_t;

    logic [1:0]         state, state_nxt;
    logic [KW-1:0]      k, k_nxt;
    logic               first_arm, first_nxt;
    logic [BLOCK_W-1:0] blk_buf, blk_nxt, blk_wr, push_blk;
    logic [BW-1:0]      wr_base;
    logic [IN_W-1:0]    wr_word;
    logic               err, push, push_final, pop, full, empty, at_last, accept, idle_rdy;
    blk_t               push_ent, head;

`ifdef LOADER_PAD_EN
    localparam int unsigned LEN_WORDS = LEN_W / IN_W;
    localparam logic [1:0]  S_PAD     = 2'(ST_PAD);
    logic [LEN_W-1:0] len, len_nxt;
    logic             pad_one, pad_one_nxt, spill, spill_nxt, len_phase;
    assign idle_rdy = 1'b1;
`else
    // pend: a short final block is waiting for FIFO room while back in IDLE.
    logic pend, pend_nxt;
    assign idle_rdy = !pend;
`endif

    assign at_last = (k == KW'(WORDS - 1));
    assign o_ready = (state == S_IDLE) ? idle_rdy : ((state == S_LOAD) && !(at_last && full));
    assign accept  = i_valid && o_ready;
    assign pop     = !empty && i_block_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k         <= '0;
            first_arm <= 1'b0;
            blk_buf   <= '0;
            err       <= 1'b0;
`ifdef LOADER_PAD_EN
            len       <= '0;
            pad_one   <= 1'b0;
            spill     <= 1'b0;
`else
            pend      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            first_arm <= first_nxt;
            blk_buf   <= blk_nxt;
            err       <= err | (i_valid & ~o_ready);
`ifdef LOADER_PAD_EN
            len       <= len_nxt;
            pad_one   <= pad_one_nxt;
            spill     <= spill_nxt;
`else
            pend      <= pend_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        first_nxt  = first_arm;
        blk_nxt    = blk_buf;
        push       = 1'b0;
        push_final = 1'b0;
        push_blk   = blk_buf;
        wr_word    = i_text;
`ifdef LOADER_PAD_EN
        len_nxt     = len;
        pad_one_nxt = pad_one;
        spill_nxt   = spill;
        len_phase   = pad_one && !spill && (k >= KW'(WORDS - LEN_WORDS));
        if (state == S_PAD) begin
            if (!pad_one)      wr_word = {1'b1, {(IN_W-1){1'b0}}};
            else if (len_phase) wr_word = len[LEN_W-1 -: IN_W];
            else               wr_word = '0;
        end
`else
        pend_nxt = pend;
`endif
        wr_base = BW'(BLOCK_W - 1 - int'(k) * IN_W);
        blk_wr  = blk_buf;
        blk_wr[wr_base -: IN_W] = wr_word;

        case (state)
            S_IDLE: begin
`ifndef LOADER_PAD_EN
                if (pend && !full) begin
                    push       = 1'b1;
                    push_final = 1'b1;
                    pend_nxt   = 1'b0;
                    blk_nxt    = '0;
                    first_nxt  = 1'b0;
                end
`endif
                if (accept && (i_text == IN_W'(START_CODE))) begin
                    state_nxt = S_LOAD;
                    k_nxt     = '0;
                    first_nxt = 1'b1;
                    blk_nxt   = '0;
`ifdef LOADER_PAD_EN
                    len_nxt   = '0;
`endif
                end
            end
            S_LOAD: begin
                push_blk = blk_wr;
                if (accept) begin
                    blk_nxt = blk_wr;
                    k_nxt   = k + KW'(1);
`ifdef LOADER_PAD_EN
                    len_nxt = len + LEN_W'(IN_W);
`endif
                    if (at_last) begin
                        push      = 1'b1;
                        blk_nxt   = '0;
                        k_nxt     = '0;
                        first_nxt = 1'b0;
                    end
                    if (i_last) begin
`ifdef LOADER_PAD_EN
                        state_nxt   = S_PAD;
                        pad_one_nxt = 1'b0;
                        spill_nxt   = 1'b0;
`else
                        state_nxt  = S_IDLE;
                        push_final = 1'b1;
                        k_nxt      = '0;
                        if (!at_last) begin
                            if (full) begin
                                pend_nxt = 1'b1;
                            end else begin
                                push      = 1'b1;
                                blk_nxt   = '0;
                                first_nxt = 1'b0;
                            end
                        end
`endif
                    end
                end
            end
`ifdef LOADER_PAD_EN
            S_PAD: begin
                push_blk = blk_wr;
                if (!(at_last && full)) begin
                    blk_nxt = blk_wr;
                    k_nxt   = k + KW'(1);
                    if (!pad_one) begin
                        pad_one_nxt = 1'b1;
                        spill_nxt   = (k >= KW'(WORDS - LEN_WORDS));
                    end
                    if (len_phase) len_nxt = len << IN_W;
                    if (at_last) begin
                        push      = 1'b1;
                        blk_nxt   = '0;
                        k_nxt     = '0;
                        first_nxt = 1'b0;
                        spill_nxt = 1'b0;
                        if (len_phase) begin
                            push_final = 1'b1;
                            state_nxt  = S_IDLE;
                        end
                    end
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    assign push_ent = '{block: push_blk, first: first_arm, is_final: push_final};

    hash_blk_fifo #(
        .T     (blk_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_ent),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign o_block       = head.block;
    assign o_first       = head.first;
    assign o_final       = head.is_final;
    assign o_block_valid = !empty;
    assign o_err         = err;

endmodule

// File: tb/tb_hash_msg_loader.sv
// Directed self-checking bench for hash_msg_loader (IN_W=8, BLOCK_W=512, FIFO_DEPTH=2).
module tb_hash_msg_loader;

    localparam int unsigned IN_W    = 8;
    localparam int unsigned BLOCK_W = 512;

    logic               clk;
    logic               rst_n;
    logic [IN_W-1:0]    i_text;
    logic               i_valid;
    logic               i_last;
    logic               o_ready;
    logic [BLOCK_W-1:0] o_block;
    logic               o_block_valid;
    logic               i_block_ready;
    logic               o_first;
    logic               o_final;
    logic               o_err;

    int n_cmp;
    int n_bad;
    logic [BLOCK_W-1:0] exp_b;

    hash_msg_loader #(
        .IN_W       (IN_W),
        .BLOCK_W    (BLOCK_W),
        .START_CODE (8'hAA),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_text        (i_text),
        .i_valid       (i_valid),
        .i_last        (i_last),
        .o_ready       (o_ready),
        .o_block       (o_block),
        .o_block_valid (o_block_valid),
        .i_block_ready (i_block_ready),
        .o_first       (o_first),
        .o_final       (o_final),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        i_text  = d;
        i_valid = 1'b1;
        i_last  = l;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic check_pop(input string tag, input logic [BLOCK_W-1:0] eb, input logic ef, input logic el);
        int w;
        w = 0;
        while (!o_block_valid && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk({tag, "_valid"}, BLOCK_W'(o_block_valid), BLOCK_W'(1));
        chk({tag, "_data"},  o_block, eb);
        chk({tag, "_first"}, BLOCK_W'(o_first), BLOCK_W'(ef));
        chk({tag, "_final"}, BLOCK_W'(o_final), BLOCK_W'(el));
        i_block_ready = 1'b1;
        @(posedge clk);
        #1;
        i_block_ready = 1'b0;
    endtask

    function automatic logic [BLOCK_W-1:0] seq_blk(input logic [7:0] start);
        logic [BLOCK_W-1:0] b;
        b = '0;
        for (int i = 0; i < 64; i++) b[BLOCK_W-1-8*i -: 8] = start + 8'(i);
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        i_text = '0;
        i_valid = 1'b0;
        i_last = 1'b0;
        i_block_ready = 1'b0;
        #12;
        chk("reset_valid", BLOCK_W'(o_block_valid), '0);
        chk("reset_block", o_block, '0);
        chk("reset_first", BLOCK_W'(o_first), '0);
        chk("reset_final", BLOCK_W'(o_final), '0);
        chk("reset_err",   BLOCK_W'(o_err), '0);
        chk("reset_ready", BLOCK_W'(o_ready), BLOCK_W'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef LOADER_PAD_EN
        // "abc": one padded block with length 24
        send(8'hAA, 1'b0);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
        exp_b = '0;
        exp_b[BLOCK_W-1 -: 32] = 32'h61626380;
        exp_b[63:0] = 64'h18;
        check_pop("abc", exp_b, 1'b1, 1'b1);

        // 56-byte message: the length spills into a second block
        send(8'hAA, 1'b0);
        for (int i = 0; i < 56; i++) send(8'(i + 1), i == 55);
        exp_b = '0;
        for (int i = 0; i < 56; i++) exp_b[BLOCK_W-1-8*i -: 8] = 8'(i + 1);
        exp_b[BLOCK_W-1-8*56 -: 8] = 8'h80;
        check_pop("m56_b1", exp_b, 1'b1, 1'b0);
        exp_b = '0;
        exp_b[63:0] = 64'h1C0;
        check_pop("m56_b2", exp_b, 1'b0, 1'b1);
`else
        // Full block 00..3F, last on the 64th byte
        send(8'hAA, 1'b0);
        for (int i = 0; i < 63; i++) send(8'(i), 1'b0);
        chk("t1_pre_valid", BLOCK_W'(o_block_valid), '0);
        send(8'h3F, 1'b1);
        chk("t1_latency", BLOCK_W'(o_block_valid), BLOCK_W'(1));
        check_pop("t1", seq_blk(8'h00), 1'b1, 1'b1);
        chk("t1_drained", BLOCK_W'(o_block_valid), '0);

        // Junk before the start code; start code inside the message is data
        send(8'h55, 1'b0);
        send(8'h00, 1'b0);
        chk("junk_valid", BLOCK_W'(o_block_valid), '0);
        chk("junk_ready", BLOCK_W'(o_ready), BLOCK_W'(1));
        send(8'hAA, 1'b0);
        send(8'h11, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h22, 1'b1);
        exp_b = '0;
        exp_b[BLOCK_W-1 -: 24] = 24'h11AA22;
        check_pop("junk", exp_b, 1'b1, 1'b1);

        // Back-pressure: three blocks with the core stalled
        send(8'hAA, 1'b0);
        for (int i = 0; i < 128; i++) send(8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 63; i++) send(8'(8'hC0 + i), 1'b0);
        chk("bp_ready_low", BLOCK_W'(o_ready), '0);
        chk("bp_err_pre", BLOCK_W'(o_err), '0);
        send(8'h00, 1'b0);
        chk("bp_err_set", BLOCK_W'(o_err), BLOCK_W'(1));
        check_pop("bp_b1", seq_blk(8'h40), 1'b1, 1'b0);
        chk("bp_ready_back", BLOCK_W'(o_ready), BLOCK_W'(1));
        send(8'hFF, 1'b1);
        check_pop("bp_b2", seq_blk(8'h80), 1'b0, 1'b0);
        check_pop("bp_b3", seq_blk(8'hC0), 1'b0, 1'b1);
        chk("bp_err_sticky", BLOCK_W'(o_err), BLOCK_W'(1));

        // Reset with one block buffered and a message 30 bytes in
        send(8'hAA, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        send(8'hAA, 1'b0);
        for (int i = 0; i < 30; i++) send(8'(i + 3), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", BLOCK_W'(o_block_valid), '0);
        chk("rst_block", o_block, '0);
        chk("rst_first", BLOCK_W'(o_first), '0);
        chk("rst_final", BLOCK_W'(o_final), '0);
        chk("rst_err",   BLOCK_W'(o_err), '0);
        chk("rst_ready", BLOCK_W'(o_ready), BLOCK_W'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_no_spurious", BLOCK_W'(o_block_valid), '0);
        end
        send(8'hAA, 1'b0);
        send(8'h5A, 1'b0);
        send(8'hC3, 1'b1);
        exp_b = '0;
        exp_b[BLOCK_W-1 -: 16] = 16'h5AC3;
        check_pop("post_rst", exp_b, 1'b1, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
